// File: rtl/cache_controller_pkg.sv
// rtl/cache_controller_pkg.sv - shared states and geometry for the data cache
package cache_controller_pkg;

    localparam int CACHE_SETS    = 64;
    localparam int SRAM_ADDR_TOP = 18;
    localparam int IDX_W         = $clog2(CACHE_SETS);
    localparam int TAG_W         = SRAM_ADDR_TOP + 1 - 2 - IDX_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        READ_MISS = 2'd1,
        WRITE     = 2'd2
    } state_t;

endpackage

// File: rtl/cache_controller_if.sv
// rtl/cache_controller_if.sv - MEM-stage and SRAM-controller signals seen by the cache
interface cache_controller_if;

    logic        memRead;
    logic        memWrite;
    logic [31:0] address;
    logic [31:0] writeData;
    logic [31:0] readData;
    logic        freeze;
    logic        sramRead;
    logic        sramWrite;
    logic [31:0] sramAddress;
    logic [31:0] sramWriteData;
    logic [31:0] sramReadData;
    logic        sramFreeze;

    modport master (
        output memRead, memWrite, address, writeData, sramReadData, sramFreeze,
        input  readData, freeze, sramRead, sramWrite, sramAddress, sramWriteData
    );

    modport slave (
        input  memRead, memWrite, address, writeData, sramReadData, sramFreeze,
        output readData, freeze, sramRead, sramWrite, sramAddress, sramWriteData
    );

endinterface

// File: rtl/cache_way_array.sv
// rtl/cache_way_array.sv - one way of valid/tag/data storage with combinational lookup
module cache_way_array
    import cache_controller_pkg::*;
#(
    parameter int SETS = CACHE_SETS,
    parameter int IW   = IDX_W,
    parameter int TW   = TAG_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] index,
    input  logic [TW-1:0] tag,
    output logic          valid,
    output logic          hit,
    output logic [31:0]   data,
    input  logic          wr_en,
    input  logic [IW-1:0] wr_index,
    input  logic [TW-1:0] wr_tag,
    input  logic [31:0]   wr_data
);

    logic [SETS-1:0] valid_q;
    logic [TW-1:0]   tag_q  [SETS];
    logic [31:0]     data_q [SETS];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= 1'b1;
        end
    end

    // Tag/data need no reset: they are only observed through a set valid bit.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            tag_q[wr_index]  <= wr_tag;
            data_q[wr_index] <= wr_data;
        end
    end

    assign valid = valid_q[index];
    assign hit   = valid_q[index] && (tag_q[index] == tag);
    assign data  = data_q[index];

endmodule

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - 2-way write-through no-write-allocate data cache in front of the SRAM controller
module cache_controller
    import cache_controller_pkg::*;
#(
    parameter int SETS = CACHE_SETS
) (
    input logic               clk,
    input logic               rst,
    cache_controller_if.slave bus
);

    localparam int IW = $clog2(SETS);
    localparam int TW = SRAM_ADDR_TOP + 1 - 2 - IW;

    state_t          state, state_next;
    logic [SETS-1:0] lru;
    logic [IW-1:0]   index;
    logic [TW-1:0]   tag;
    logic            valid0, valid1, hit0, hit1;
    logic [31:0]     data0, data1;
    logic            wr_en0, wr_en1;
    logic [31:0]     wr_data;
    logic            lru_we, lru_val;
    logic            victim1;
    logic            unused_addr;

    assign index       = bus.address[2 +: IW];
    assign tag         = bus.address[SRAM_ADDR_TOP : 2 + IW];
    assign unused_addr = ^{bus.address[31:SRAM_ADDR_TOP + 1], bus.address[1:0]};

    cache_way_array #(.SETS(SETS), .IW(IW), .TW(TW)) way0 (
        .clk(clk), .rst(rst), .index(index), .tag(tag),
        .valid(valid0), .hit(hit0), .data(data0),
        .wr_en(wr_en0), .wr_index(index), .wr_tag(tag), .wr_data(wr_data)
    );

    cache_way_array #(.SETS(SETS), .IW(IW), .TW(TW)) way1 (
        .clk(clk), .rst(rst), .index(index), .tag(tag),
        .valid(valid1), .hit(hit1), .data(data1),
        .wr_en(wr_en1), .wr_index(index), .wr_tag(tag), .wr_data(wr_data)
    );

    // Fill the first invalid way, else the LRU one (lru=1 means way1 is LRU).
    assign victim1 = valid0 && (!valid1 || lru[index]);

    assign bus.sramAddress   = bus.address;
    assign bus.sramWriteData = bus.writeData;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            lru   <= '0;
        end else begin
            state <= state_next;
            if (lru_we) begin
                lru[index] <= lru_val;
            end
        end
    end

    always_comb begin
        state_next    = state;
        bus.freeze    = 1'b0;
        bus.sramRead  = 1'b0;
        bus.sramWrite = 1'b0;
        bus.readData  = '0;
        wr_en0        = 1'b0;
        wr_en1        = 1'b0;
        wr_data       = bus.writeData;
        lru_we        = 1'b0;
        lru_val       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.memWrite) begin
                    state_next = WRITE;
                    bus.freeze = 1'b1;
                end else if (bus.memRead) begin
                    if (hit0 || hit1) begin
                        bus.readData = hit0 ? data0 : data1;
                        lru_we       = 1'b1;
                        lru_val      = hit0;
                    end else begin
                        state_next = READ_MISS;
                        bus.freeze = 1'b1;
                    end
                end
            end
            READ_MISS: begin
                bus.sramRead = 1'b1;
                if (bus.sramFreeze) begin
                    bus.freeze = 1'b1;
                end else begin
                    bus.readData = bus.sramReadData;
                    wr_data      = bus.sramReadData;
                    wr_en0       = !victim1;
                    wr_en1       = victim1;
                    lru_we       = 1'b1;
                    lru_val      = !victim1;
                    state_next   = IDLE;
                end
            end
            WRITE: begin
                bus.sramWrite = 1'b1;
                if (bus.sramFreeze) begin
                    bus.freeze = 1'b1;
                end else begin
                    wr_en0     = hit0;
                    wr_en1     = hit1;
                    lru_we     = hit0 || hit1;
                    lru_val    = hit0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - directed self-checking bench with a 4-cycle SRAM controller stub
module tb_cache_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   stub_cnt = 0;
    logic [31:0] mem [4096];

    cache_controller_if bus_if();

    cache_controller dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if.slave)
    );

    always #5 clk = ~clk;

    // Controller stub: busy for 4 cycles after a request appears, word array behind it.
    assign bus_if.sramFreeze   = (bus_if.sramRead || bus_if.sramWrite) && (stub_cnt < 4);
    assign bus_if.sramReadData = mem[bus_if.sramAddress[13:2]];

    always @(posedge clk) begin
        if (rst || !(bus_if.sramRead || bus_if.sramWrite)) stub_cnt <= 0;
        else stub_cnt <= stub_cnt + 1;
        if (bus_if.sramWrite && !bus_if.sramFreeze)
            mem[bus_if.sramAddress[13:2]] <= bus_if.sramWriteData;
    end

    task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, output int fcyc, output int nrd,
                             output int nwr, output logic [31:0] rdata,
                             output logic [31:0] swdata, output logic tout);
        logic prev_rd, prev_wr;
        fcyc = 0; nrd = 0; nwr = 0; rdata = '0; swdata = '0; tout = 1'b1;
        prev_rd = 1'b0; prev_wr = 1'b0;
        @(negedge clk);
        bus_if.memRead   = rd;
        bus_if.memWrite  = wr;
        bus_if.address   = addr;
        bus_if.writeData = wdata;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (bus_if.sramRead && !prev_rd) nrd++;
            if (bus_if.sramWrite && !prev_wr) nwr++;
            prev_rd = bus_if.sramRead;
            prev_wr = bus_if.sramWrite;
            if (bus_if.sramWrite) swdata = bus_if.sramWriteData;
            if (!bus_if.freeze) begin
                rdata = bus_if.readData;
                tout  = 1'b0;
                break;
            end
            fcyc++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus_if.memRead  = 1'b0;
        bus_if.memWrite = 1'b0;
    endtask

    task automatic test_reset;
        bus_if.memRead = 1'b0; bus_if.memWrite = 1'b0;
        bus_if.address = 32'hABCD_0004; bus_if.writeData = 32'h55AA_55AA;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus_if.freeze, bus_if.sramRead, bus_if.sramWrite} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl got %b want 000", {bus_if.freeze, bus_if.sramRead, bus_if.sramWrite});
        end
        checks++;
        if (bus_if.readData !== 32'h0) begin
            errors++; $display("FAIL reset_rdata got %h want 00000000", bus_if.readData);
        end
        checks++;
        if (bus_if.sramAddress !== 32'hABCD_0004 || bus_if.sramWriteData !== 32'h55AA_55AA) begin
            errors++; $display("FAIL idle_passthru got %h/%h want abcd0004/55aa55aa", bus_if.sramAddress, bus_if.sramWriteData);
        end
        rst = 1'b0;
    endtask

    task automatic test_cold_miss;
        int f, nr, nw; logic [31:0] rd, sw; logic t;
        do_access(1'b1, 1'b0, 32'h0000_1000, 32'h0, f, nr, nw, rd, sw, t);
        checks++;
        if (t || f != 5) begin errors++; $display("FAIL cold_freeze got %0d (timeout %0b) want 5", f, t); end
        checks++;
        if (nr != 1 || nw != 0) begin errors++; $display("FAIL cold_sram_reqs got rd=%0d wr=%0d want 1/0", nr, nw); end
        checks++;
        if (rd !== 32'hC0DE_0400) begin errors++; $display("FAIL cold_rdata got %h want c0de0400", rd); end
    endtask

    task automatic test_read_hit;
        int f, nr, nw; logic [31:0] rd, sw; logic t;
        do_access(1'b1, 1'b0, 32'h0000_1000, 32'h0, f, nr, nw, rd, sw, t);
        checks++;
        if (t || f != 0 || nr != 0) begin errors++; $display("FAIL hit_nostall got freeze=%0d sramRead=%0d want 0/0", f, nr); end
        checks++;
        if (rd !== 32'hC0DE_0400) begin errors++; $display("FAIL hit_rdata got %h want c0de0400", rd); end
    endtask

    task automatic test_store_hit;
        int f, nr, nw; logic [31:0] rd, sw; logic t;
        do_access(1'b0, 1'b1, 32'h0000_1000, 32'h1234_5678, f, nr, nw, rd, sw, t);
        checks++;
        if (t || f != 5 || nw != 1) begin errors++; $display("FAIL store_freeze got %0d sramWrite=%0d want 5/1", f, nw); end
        checks++;
        if (sw !== 32'h1234_5678) begin errors++; $display("FAIL store_wdata got %h want 12345678", sw); end
        do_access(1'b1, 1'b0, 32'h0000_1000, 32'h0, f, nr, nw, rd, sw, t);
        checks++;
        if (t || f != 0 || rd !== 32'h1234_5678) begin
            errors++; $display("FAIL store_then_hit got freeze=%0d data=%h want 0/12345678", f, rd);
        end
    endtask

    task automatic test_no_write_allocate;
        int f, nr, nw; logic [31:0] rd, sw; logic t;
        do_access(1'b0, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, f, nr, nw, rd, sw, t);
        checks++;
        if (t || f != 5) begin errors++; $display("FAIL nwa_store got %0d want 5", f); end
        do_access(1'b1, 1'b0, 32'h0000_2000, 32'h0, f, nr, nw, rd, sw, t);
        checks++;
        if (t || f != 5 || nr != 1) begin errors++; $display("FAIL nwa_load_miss got freeze=%0d sramRead=%0d want 5/1", f, nr); end
        checks++;
        if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL nwa_load_data got %h want deadbeef", rd); end
        do_access(1'b1, 1'b0, 32'h0000_2000, 32'h0, f, nr, nw, rd, sw, t);
        checks++;
        if (t || f != 0) begin errors++; $display("FAIL nwa_reload_hit got %0d want 0", f); end
    endtask

    task automatic test_conflict;
        logic [31:0] addrs [6] = '{32'h0000, 32'h0100, 32'h0000, 32'h0200, 32'h0000, 32'h0100};
        int          exp_f [6] = '{5, 5, 0, 5, 0, 5};
        logic [31:0] exp_d [6] = '{32'hC0DE_0000, 32'hC0DE_0040, 32'hC0DE_0000,
                                   32'hC0DE_0080, 32'hC0DE_0000, 32'hC0DE_0040};
        int f, nr, nw; logic [31:0] rd, sw; logic t;
        for (int i = 0; i < 6; i++) begin
            do_access(1'b1, 1'b0, addrs[i], 32'h0, f, nr, nw, rd, sw, t);
            checks++;
            if (t || f != exp_f[i] || rd !== exp_d[i]) begin
                errors++;
                $display("FAIL conflict_%0d got freeze=%0d data=%h want %0d/%h", i, f, rd, exp_f[i], exp_d[i]);
            end
        end
    endtask

    task automatic test_reset_mid_miss;
        int f, nr, nw; logic [31:0] rd, sw; logic t;
        @(negedge clk);
        bus_if.memRead = 1'b1; bus_if.address = 32'h0000_3000;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (bus_if.sramRead !== 1'b1) begin errors++; $display("FAIL mid_miss_active got %b want 1", bus_if.sramRead); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus_if.sramRead !== 1'b0) begin errors++; $display("FAIL rst_drop_read got %b want 0", bus_if.sramRead); end
        bus_if.memRead = 1'b0;
        #1;
        checks++;
        if (bus_if.freeze !== 1'b0) begin errors++; $display("FAIL rst_drop_freeze got %b want 0", bus_if.freeze); end
        @(negedge clk);
        rst = 1'b0;
        do_access(1'b1, 1'b0, 32'h0000_3000, 32'h0, f, nr, nw, rd, sw, t);
        checks++;
        if (t || f != 5 || nr != 1) begin errors++; $display("FAIL rst_no_fill got freeze=%0d sramRead=%0d want 5/1", f, nr); end
        checks++;
        if (rd !== 32'hC0DE_0C00) begin errors++; $display("FAIL rst_reload_data got %h want c0de0c00", rd); end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 32'hC0DE_0000 + i;
        test_reset();
        test_cold_miss();
        test_read_hit();
        test_store_hit();
        test_no_write_allocate();
        test_conflict();
        test_reset_mid_miss();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
